// File: rtl/rv_data_arbiter_if.sv
// Bundles the two requester ports and the shared downstream data port of rv_data_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface rv_data_arbiter_if #(
    parameter int XLEN = 32
);
    logic              m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
    logic [XLEN/8-1:0] m0_be_i;
    logic [XLEN-1:0]   m0_addr_i, m0_wdata_i, m0_rdata_o;

    logic              m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
    logic [XLEN/8-1:0] m1_be_i;
    logic [XLEN-1:0]   m1_addr_i, m1_wdata_i, m1_rdata_o;

    logic              data_req_o, data_we_o, data_rvalid_i;
    logic [XLEN/8-1:0] data_be_o;
    logic [XLEN-1:0]   data_addr_o, data_wdata_o, data_rdata_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_rvalid_i, data_rdata_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/rv_data_arbiter.sv
// Round-robin arbiter between the LSU (m0) and a secondary requester (m1) for the data port,
// with an in-order ID FIFO that steers each response back to the master that issued it.
module rv_data_arbiter #(
    parameter int XLEN      = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    rv_data_arbiter_if.slave   bus,
    output logic               err_o
);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTST - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTST);

    logic [MAX_OUTST-1:0] ids_q, ids_d;
    logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 prio_q, prio_d;
    logic                 err_q, err_d;

    logic can_issue, gnt0, gnt1, push, pop, head_id, empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ids_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            prio_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ids_q   <= ids_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
        end
    end

    // A response arriving this cycle frees its slot, so it can admit a new request immediately.
    always_comb begin
        empty     = (count_q == '0);
        can_issue = (count_q < CNT_MAX) | bus.data_rvalid_i;
        gnt0      = can_issue & bus.m0_req_i & (~bus.m1_req_i | ~prio_q);
        gnt1      = can_issue & bus.m1_req_i & (~bus.m0_req_i |  prio_q);
        push      = gnt0 | gnt1;
        pop       = bus.data_rvalid_i & ~empty;
        head_id   = ids_q[rptr_q];
    end

    always_comb begin
        ids_d   = ids_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        prio_d  = prio_q;
        if (push) begin
            ids_d[wptr_q] = gnt1;
            wptr_d        = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
            prio_d        = ~gnt1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        // An unsolicited response is a protocol violation by the downstream and is latched.
        err_d = err_q | (bus.data_rvalid_i & empty);
    end

    always_comb begin
        bus.m0_gnt_o     = gnt0;
        bus.m1_gnt_o     = gnt1;
        bus.data_req_o   = push;
        bus.data_we_o    = 1'b0;
        bus.data_be_o    = '0;
        bus.data_addr_o  = '0;
        bus.data_wdata_o = '0;
        if (gnt0) begin
            bus.data_we_o    = bus.m0_we_i;
            bus.data_be_o    = bus.m0_be_i;
            bus.data_addr_o  = bus.m0_addr_i;
            bus.data_wdata_o = bus.m0_wdata_i;
        end else if (gnt1) begin
            bus.data_we_o    = bus.m1_we_i;
            bus.data_be_o    = bus.m1_be_i;
            bus.data_addr_o  = bus.m1_addr_i;
            bus.data_wdata_o = bus.m1_wdata_i;
        end
        bus.m0_rvalid_o = pop & ~head_id;
        bus.m1_rvalid_o = pop &  head_id;
        bus.m0_rdata_o  = (pop & ~head_id) ? bus.data_rdata_i : '0;
        bus.m1_rdata_o  = (pop &  head_id) ? bus.data_rdata_i : '0;
        err_o           = err_q;
    end
endmodule
